// File: rtl/ascon_ctrl_fsm_if.sv
// Handshake and datapath-control bundle between the ASCON control FSM and its
// data source / permutation datapath.
interface ascon_ctrl_fsm_if;
  logic        start_i;
  logic        data_valid_i;
  logic [63:0] data_i;
  logic        data_ready_o;
  logic [63:0] data_o;
  logic        select_o;
  logic [3:0]  round_o;
  logic        enable_o;
  logic [1:0]  etat_o;
  logic [1:0]  etat_down_o;
  logic        cipher_valid_o;
  logic        tag_valid_o;
  logic        busy_o;
  logic        end_o;

  modport master (
    output start_i, data_valid_i, data_i,
    input  data_ready_o, data_o, select_o, round_o, enable_o, etat_o,
           etat_down_o, cipher_valid_o, tag_valid_o, busy_o, end_o
  );

  modport slave (
    input  start_i, data_valid_i, data_i,
    output data_ready_o, data_o, select_o, round_o, enable_o, etat_o,
           etat_down_o, cipher_valid_o, tag_valid_o, busy_o, end_o
  );
endinterface

// File: rtl/ascon_ctrl_fsm.sv
// Sequences one ASCON-128 encryption (init, AD, PT, final) over the permutation
// datapath; data blocks are captured on valid/ready and held until the next one.
module ascon_ctrl_fsm #(
  parameter int ROUNDS_A = 12,
  parameter int ROUNDS_B = 6,
  parameter int NB_AD    = 1,
  parameter int NB_PT    = 4
) (
  input  logic           clock_i,
  input  logic           resetb_i,
  ascon_ctrl_fsm_if.slave bus
);

  localparam int NB_MAX = (NB_AD > NB_PT) ? NB_AD : NB_PT;
  localparam int BW     = $clog2(NB_MAX + 1);

  localparam logic [3:0]    RND_A0   = 4'(12 - ROUNDS_A);
  localparam logic [3:0]    RND_B0   = 4'(12 - ROUNDS_B);
  localparam logic [3:0]    RND_LAST = 4'd11;
  localparam logic [BW-1:0] AD_LAST  = BW'(NB_AD);
  localparam logic [BW-1:0] PT_LAST  = BW'(NB_PT - 1);

  typedef enum logic [2:0] {
    S_IDLE, S_INIT, S_WAIT_AD, S_AD, S_WAIT_PT, S_PT, S_FINAL, S_DONE
  } state_t;

  state_t        state, state_nxt;
  logic [3:0]    rnd;
  logic [BW-1:0] ad_cnt, pt_cnt;
  logic [63:0]   data_q;

  logic       rdy, en, sel, cv, tv, endp, hs, last_rnd;
  logic [3:0] rnd_out;
  logic [1:0] et, etd;

  assign hs       = bus.data_valid_i && rdy;
  assign last_rnd = (rnd == RND_LAST);

  always_ff @(posedge clock_i or negedge resetb_i) begin
    if (!resetb_i) state <= S_IDLE;
    else           state <= state_nxt;
  end

  // Round counter is preloaded at each handshake so the next permutation
  // starts at the right constant without a dead cycle.
  always_ff @(posedge clock_i or negedge resetb_i) begin
    if (!resetb_i) begin
      rnd    <= 4'd0;
      ad_cnt <= '0;
      pt_cnt <= '0;
      data_q <= 64'd0;
    end else begin
      case (state)
        S_IDLE: if (bus.start_i) begin
          rnd    <= RND_A0;
          ad_cnt <= '0;
          pt_cnt <= '0;
        end
        S_INIT, S_AD, S_PT, S_FINAL: rnd <= last_rnd ? 4'd0 : rnd + 4'd1;
        S_WAIT_AD: if (hs) begin
          rnd    <= RND_B0;
          ad_cnt <= ad_cnt + BW'(1);
          data_q <= bus.data_i;
        end
        S_WAIT_PT: if (hs) begin
          rnd    <= (pt_cnt == PT_LAST) ? RND_A0 : RND_B0;
          pt_cnt <= pt_cnt + BW'(1);
          data_q <= bus.data_i;
        end
        default: ;
      endcase
    end
  end

  always_comb begin
    state_nxt = state;
    case (state)
      S_IDLE:    if (bus.start_i) state_nxt = S_INIT;
      S_INIT:    if (last_rnd) state_nxt = S_WAIT_AD;
      S_WAIT_AD: if (hs) state_nxt = S_AD;
      S_AD:      if (last_rnd) state_nxt = (ad_cnt == AD_LAST) ? S_WAIT_PT : S_WAIT_AD;
      S_WAIT_PT: if (hs) state_nxt = (pt_cnt == PT_LAST) ? S_FINAL : S_PT;
      S_PT:      if (last_rnd) state_nxt = S_WAIT_PT;
      S_FINAL:   if (last_rnd) state_nxt = S_DONE;
      S_DONE:    state_nxt = S_IDLE;
      default:   state_nxt = S_IDLE;
    endcase
  end

  always_comb begin
    rdy     = 1'b0;
    en      = 1'b0;
    sel     = 1'b0;
    cv      = 1'b0;
    tv      = 1'b0;
    endp    = 1'b0;
    et      = 2'b00;
    etd     = 2'b00;
    rnd_out = 4'd0;
    case (state)
      S_INIT: begin
        en      = 1'b1;
        rnd_out = rnd;
        sel     = (rnd == RND_A0);
        etd     = last_rnd ? 2'b01 : 2'b00;
      end
      S_WAIT_AD, S_WAIT_PT: rdy = 1'b1;
      S_AD: begin
        en      = 1'b1;
        rnd_out = rnd;
        et      = (rnd == RND_B0) ? 2'b01 : 2'b00;
        etd     = (last_rnd && ad_cnt == AD_LAST) ? 2'b10 : 2'b00;
      end
      S_PT: begin
        en      = 1'b1;
        rnd_out = rnd;
        et      = (rnd == RND_B0) ? 2'b01 : 2'b00;
        cv      = (rnd == RND_B0);
      end
      S_FINAL: begin
        en      = 1'b1;
        rnd_out = rnd;
        et      = (rnd == RND_A0) ? 2'b11 : 2'b00;
        cv      = (rnd == RND_A0);
        etd     = last_rnd ? 2'b01 : 2'b00;
      end
      S_DONE: begin
        tv   = 1'b1;
        endp = 1'b1;
      end
      default: ;
    endcase
  end

  assign bus.data_ready_o   = rdy;
  assign bus.data_o         = data_q;
  assign bus.select_o       = sel;
  assign bus.round_o        = rnd_out;
  assign bus.enable_o       = en;
  assign bus.etat_o         = et;
  assign bus.etat_down_o    = etd;
  assign bus.cipher_valid_o = cv;
  assign bus.tag_valid_o    = tv;
  assign bus.busy_o         = (state != S_IDLE);
  assign bus.end_o          = endp;

endmodule

// File: tb/tb_ascon_ctrl_fsm.sv
// Directed bench for ascon_ctrl_fsm: default config (NB_AD=1, NB_PT=4) and
// NB_AD=2 / NB_PT=1, compared cycle by cycle against a hand-built schedule.
module tb_ascon_ctrl_fsm;
  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  ascon_ctrl_fsm_if if0 ();
  ascon_ctrl_fsm_if if1 ();

  ascon_ctrl_fsm #(.ROUNDS_A(12), .ROUNDS_B(6), .NB_AD(1), .NB_PT(4)) u_dut0 (
    .clock_i(clk), .resetb_i(rst_n), .bus(if0.slave));
  ascon_ctrl_fsm #(.ROUNDS_A(12), .ROUNDS_B(6), .NB_AD(2), .NB_PT(1)) u_dut1 (
    .clock_i(clk), .resetb_i(rst_n), .bus(if1.slave));

  int checks = 0;
  int errors = 0;

  logic [63:0] blk [0:4];
  logic [14:0] obs_tr [0:99];
  logic [14:0] exp_tr [0:99];
  logic [63:0] dat_tr [0:99];
  logic [63:0] dat_seen [0:7];

  // {en, sel, round[3:0], etat[1:0], etat_down[1:0], cv, tv, end, ready, busy}
  function automatic logic [14:0] pack(input int s);
    if (s == 0)
      return {if0.enable_o, if0.select_o, if0.round_o, if0.etat_o, if0.etat_down_o,
              if0.cipher_valid_o, if0.tag_valid_o, if0.end_o, if0.data_ready_o, if0.busy_o};
    return {if1.enable_o, if1.select_o, if1.round_o, if1.etat_o, if1.etat_down_o,
            if1.cipher_valid_o, if1.tag_valid_o, if1.end_o, if1.data_ready_o, if1.busy_o};
  endfunction

  function automatic logic [14:0] mk(input logic en, input logic sl, input int rnd,
                                     input int et, input int etd, input logic cv,
                                     input logic tv, input logic ed, input logic rdy,
                                     input logic bsy);
    return {en, sl, 4'(rnd), 2'(et), 2'(etd), cv, tv, ed, rdy, bsy};
  endfunction

  task automatic set_in(input int s, input logic st, input logic vld, input logic [63:0] d);
    if (s == 0) begin
      if0.start_i = st; if0.data_valid_i = vld; if0.data_i = d;
    end else begin
      if1.start_i = st; if1.data_valid_i = vld; if1.data_i = d;
    end
  endtask

  // Expected per-cycle outputs; cycle 1 is the first INIT cycle after start is sampled.
  task automatic build_exp(input int nb_ad, input int nb_pt, input int bp, output int last);
    int c;
    for (int i = 0; i < 100; i++) exp_tr[i] = '0;
    c = 1;
    for (int r = 0; r < 12; r++) exp_tr[c++] = mk(1, r == 0, r, 0, (r == 11) ? 1 : 0, 0, 0, 0, 0, 1);
    for (int a = 1; a <= nb_ad; a++) begin
      exp_tr[c++] = mk(0, 0, 0, 0, 0, 0, 0, 0, 1, 1);
      for (int r = 6; r < 12; r++)
        exp_tr[c++] = mk(1, 0, r, (r == 6) ? 1 : 0, (r == 11 && a == nb_ad) ? 2 : 0, 0, 0, 0, 0, 1);
    end
    for (int p = 1; p < nb_pt; p++) begin
      for (int w = 0; w < ((p == 2) ? 1 + bp : 1); w++) exp_tr[c++] = mk(0, 0, 0, 0, 0, 0, 0, 0, 1, 1);
      for (int r = 6; r < 12; r++)
        exp_tr[c++] = mk(1, 0, r, (r == 6) ? 1 : 0, 0, r == 6, 0, 0, 0, 1);
    end
    exp_tr[c++] = mk(0, 0, 0, 0, 0, 0, 0, 0, 1, 1);
    for (int r = 0; r < 12; r++)
      exp_tr[c++] = mk(1, 0, r, (r == 0) ? 3 : 0, (r == 11) ? 1 : 0, r == 0, 0, 0, 0, 1);
    exp_tr[c] = mk(0, 0, 0, 0, 0, 0, 1, 1, 0, 1);
    last = c;
  endtask

  // Called at a negedge; drives one encryption and records outputs per cycle.
  task automatic drive_run(input int s, input int bp, input int pulse, input int ncyc);
    int   hs = 0;
    int   bp_left = bp;
    logic pend = 1'b0;
    logic rdy, vld;
    for (int c = 0; c <= ncyc; c++) begin
      if (c > 0) @(negedge clk);
      obs_tr[c] = pack(s);
      dat_tr[c] = (s == 0) ? if0.data_o : if1.data_o;
      if (pend) begin dat_seen[hs-1] = dat_tr[c]; pend = 1'b0; end
      rdy = obs_tr[c][1];
      vld = 1'b1;
      if (rdy && hs == 2 && bp_left > 0) begin vld = 1'b0; bp_left--; end
      set_in(s, (c == 0) || (c == pulse), vld, blk[(hs > 4) ? 4 : hs]);
      if (rdy && vld) begin hs++; pend = 1'b1; end
    end
    set_in(s, 1'b0, 1'b0, 64'd0);
  endtask

  task automatic test_reset();
    set_in(0, 1'b0, 1'b0, 64'd0);
    set_in(1, 1'b0, 1'b0, 64'd0);
    rst_n = 1'b0;
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    for (int c = 0; c < 20; c++) begin
      @(negedge clk);
      checks++;
      if (pack(0) !== 15'd0 || if0.data_o !== 64'd0) begin
        errors++;
        $display("FAIL reset_idle0 cyc %0d: got %h data %h, want 0", c, pack(0), if0.data_o);
      end
      checks++;
      if (pack(1) !== 15'd0 || if1.data_o !== 64'd0) begin
        errors++;
        $display("FAIL reset_idle1 cyc %0d: got %h data %h, want 0", c, pack(1), if1.data_o);
      end
    end
  endtask

  task automatic test_nominal();
    int last, ncv;
    build_exp(1, 4, 0, last);
    drive_run(0, 0, -1, last + 1);
    for (int c = 0; c <= last + 1; c++) begin
      checks++;
      if (obs_tr[c] !== exp_tr[c]) begin
        errors++;
        $display("FAIL nominal cyc %0d: got %h want %h", c, obs_tr[c], exp_tr[c]);
      end
    end
    for (int n = 0; n < 5; n++) begin
      checks++;
      if (dat_seen[n] !== blk[n]) begin
        errors++;
        $display("FAIL nominal_data blk %0d: got %h want %h", n, dat_seen[n], blk[n]);
      end
    end
    ncv = 0;
    for (int c = 0; c <= last + 1; c++) ncv += obs_tr[c][4];
    checks++;
    if (ncv != 4) begin errors++; $display("FAIL nominal_cv_count: got %0d want 4", ncv); end
    checks++;
    if (obs_tr[54][2] !== 1'b1 || obs_tr[54][3] !== 1'b1) begin
      errors++;
      $display("FAIL nominal_end54: got end %b tag %b want 1 1", obs_tr[54][2], obs_tr[54][3]);
    end
  endtask

  task automatic test_backpressure();
    int last;
    build_exp(1, 4, 5, last);
    drive_run(0, 5, -1, last + 1);
    for (int c = 0; c <= last + 1; c++) begin
      checks++;
      if (obs_tr[c] !== exp_tr[c]) begin
        errors++;
        $display("FAIL backpressure cyc %0d: got %h want %h", c, obs_tr[c], exp_tr[c]);
      end
    end
    for (int c = 27; c <= 32; c++) begin
      checks++;
      if (dat_tr[c] !== blk[1]) begin
        errors++;
        $display("FAIL bp_data_hold cyc %0d: got %h want %h", c, dat_tr[c], blk[1]);
      end
    end
    checks++;
    if (obs_tr[59][2] !== 1'b1) begin
      errors++;
      $display("FAIL bp_end59: got %b want 1", obs_tr[59][2]);
    end
  endtask

  task automatic test_start_busy();
    int last;
    build_exp(1, 4, 0, last);
    drive_run(0, 0, 16, last + 1);
    for (int c = 0; c <= last + 1; c++) begin
      checks++;
      if (obs_tr[c] !== exp_tr[c]) begin
        errors++;
        $display("FAIL start_busy cyc %0d: got %h want %h", c, obs_tr[c], exp_tr[c]);
      end
    end
  endtask

  task automatic test_reset_mid();
    int last;
    drive_run(0, 0, -1, 47);
    checks++;
    if (obs_tr[47][14] !== 1'b1 || obs_tr[47][12:9] !== 4'd5) begin
      errors++;
      $display("FAIL mid_final_pos: got en %b round %0d want 1 5", obs_tr[47][14], obs_tr[47][12:9]);
    end
    #2 rst_n = 1'b0;
    #1;
    checks++;
    if (pack(0) !== 15'd0 || if0.data_o !== 64'd0) begin
      errors++;
      $display("FAIL async_reset: got %h data %h want 0", pack(0), if0.data_o);
    end
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    for (int c = 0; c < 20; c++) begin
      @(negedge clk);
      checks++;
      if (pack(0) !== 15'd0) begin
        errors++;
        $display("FAIL post_reset_idle cyc %0d: got %h want 0", c, pack(0));
      end
    end
    build_exp(1, 4, 0, last);
    drive_run(0, 0, -1, last + 1);
    for (int c = 0; c <= last + 1; c++) begin
      checks++;
      if (obs_tr[c] !== exp_tr[c]) begin
        errors++;
        $display("FAIL restart cyc %0d: got %h want %h", c, obs_tr[c], exp_tr[c]);
      end
    end
  endtask

  task automatic test_nb_ad2_pt1();
    int last, ncv;
    build_exp(2, 1, 0, last);
    drive_run(1, 0, -1, last + 1);
    for (int c = 0; c <= last + 1; c++) begin
      checks++;
      if (obs_tr[c] !== exp_tr[c]) begin
        errors++;
        $display("FAIL nb21 cyc %0d: got %h want %h", c, obs_tr[c], exp_tr[c]);
      end
    end
    for (int n = 0; n < 3; n++) begin
      checks++;
      if (dat_seen[n] !== blk[n]) begin
        errors++;
        $display("FAIL nb21_data blk %0d: got %h want %h", n, dat_seen[n], blk[n]);
      end
    end
    ncv = 0;
    for (int c = 0; c <= last + 1; c++) ncv += obs_tr[c][4];
    checks++;
    if (ncv != 1) begin errors++; $display("FAIL nb21_cv_count: got %0d want 1", ncv); end
    checks++;
    if (obs_tr[40][2] !== 1'b1 || obs_tr[19][6:5] !== 2'b00 || obs_tr[26][6:5] !== 2'b10) begin
      errors++;
      $display("FAIL nb21_marks: end40 %b etd19 %b etd26 %b want 1 00 10",
               obs_tr[40][2], obs_tr[19][6:5], obs_tr[26][6:5]);
    end
  endtask

  initial begin
    blk[0] = 64'h80400C0600000000;
    blk[1] = 64'h5A5B5B5A5A5A5A5A;
    blk[2] = 64'h5A5B5B5A5A5A5A5B;
    blk[3] = 64'h5A5B5B5A5A5A5A5C;
    blk[4] = 64'h5A5B5B5A5A5A5A5D;
    test_reset();
    test_nominal();
    test_backpressure();
    test_start_busy();
    test_reset_mid();
    test_nb_ad2_pt1();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
